// File: rtl/cute_lock_key_sequencer_pkg.sv
// Shared types and defaults for the Cute-Lock key sequencer and the
// lock-insertion flow that reuses its phase counter.
package cute_lock_pkg;

    typedef enum logic {
        KS_IDLE = 1'b0,
        KS_RUN  = 1'b1
    } keyseq_state_t;

    localparam int CL_NUM_KEYS = 4;
    localparam int CL_KEY_BITS = 4;

    // Width of a key-phase / key-slot index for n keys.
    function automatic int cl_idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/cute_lock_key_sequencer_if.sv
// Key load and key stream signals between the key store/loader (master)
// and the key sequencer (slave). load_index carries one extra MSB so that
// out-of-range slot numbers reach the sequencer and can be flagged.
interface cute_lock_key_sequencer_if
    import cute_lock_pkg::*;
#(
    parameter int NUM_KEYS = CL_NUM_KEYS,
    parameter int KEY_BITS = CL_KEY_BITS
);
    logic                           load_valid;
    logic                           load_ready;
    logic [cl_idx_w(NUM_KEYS):0]    load_index;
    logic [KEY_BITS-1:0]            load_data;
    logic                           sync;
    logic                           stop;
    logic [KEY_BITS-1:0]            keyinput;
    logic [cl_idx_w(NUM_KEYS)-1:0]  key_index;
    logic                           key_valid;
    logic                           load_err;

    modport master (
        output load_valid, load_index, load_data, sync, stop,
        input  load_ready, keyinput, key_index, key_valid, load_err
    );

    modport slave (
        input  load_valid, load_index, load_data, sync, stop,
        output load_ready, keyinput, key_index, key_valid, load_err
    );

endinterface

// File: rtl/cute_lock_key_sequencer_phase_counter.sv
// Modulo-NUM_KEYS key-phase counter with synchronous clear and enable.
// o_count_next exposes the value the counter takes at the coming edge so a
// caller can register data indexed by the new phase in the same cycle.
module keyseq_phase_counter
    import cute_lock_pkg::*;
#(
    parameter int NUM_KEYS = CL_NUM_KEYS,
    localparam int W = cl_idx_w(NUM_KEYS)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_count_next
);
    localparam logic [W-1:0] LP_MAX = W'(NUM_KEYS - 1);

    logic [W-1:0] r_count;
    logic [W-1:0] w_next;

    // Next phase: clear has priority, otherwise wrap-around increment.
    always_comb begin
        w_next = r_count;
        if (i_clr) begin
            w_next = '0;
        end else if (i_en) begin
            w_next = (r_count == LP_MAX) ? '0 : r_count + 1'b1;
        end
    end

    // Phase register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_count      = r_count;
    assign o_count_next = w_next;

endmodule

// File: rtl/cute_lock_key_sequencer.sv
// Cute-Lock key sequencer: stores NUM_KEYS keys and streams one per cycle
// onto the locked core's keyinput bus, in step with the core's key phase.
// Optional build macro KEYSEQ_LOCKOUT_EN: blocks key writes while
// streaming and flags any attempted write during RUN as a load error.
//
// state   | meaning
// KS_IDLE | outputs held at zero, waiting for sync
// KS_RUN  | streaming key[phase], phase advancing every cycle
module cute_lock_key_sequencer
    import cute_lock_pkg::*;
#(
    parameter int NUM_KEYS = CL_NUM_KEYS,
    parameter int KEY_BITS = CL_KEY_BITS
) (
    input  logic                      clock,
    input  logic                      reset,
    cute_lock_key_sequencer_if.slave  bus
);
    localparam int IDXW = cl_idx_w(NUM_KEYS);
    localparam logic [IDXW:0] LP_NUM_KEYS = (IDXW + 1)'(NUM_KEYS);

    keyseq_state_t       r_state;
    keyseq_state_t       w_state_next;
    logic [KEY_BITS-1:0] r_keys [NUM_KEYS];
    logic [KEY_BITS-1:0] r_keyinput;
    logic                r_load_err;
    logic [IDXW-1:0]     w_phase;
    logic [IDXW-1:0]     w_phase_next;
    logic                w_run;
    logic                w_ready;
    logic                w_xfer;
    logic                w_in_range;
    logic                w_lock_err;

    assign w_run = (r_state == KS_RUN);

`ifdef KEYSEQ_LOCKOUT_EN
    assign w_ready    = !w_run;
    assign w_lock_err = bus.load_valid && w_run;
`else
    assign w_ready    = 1'b1;
    assign w_lock_err = 1'b0;
`endif

    assign w_xfer     = bus.load_valid && w_ready;
    assign w_in_range = (bus.load_index < LP_NUM_KEYS);

    // Stop also clears the phase so key_index reads zero while idle.
    keyseq_phase_counter #(.NUM_KEYS(NUM_KEYS)) u_phase (
        .clock        (clock),
        .reset        (reset),
        .i_clr        (bus.sync || bus.stop),
        .i_en         (w_run),
        .o_count      (w_phase),
        .o_count_next (w_phase_next)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= KS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: sync starts streaming, stop wins over a simultaneous sync.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            KS_IDLE: if (bus.sync && !bus.stop) w_state_next = KS_RUN;
            KS_RUN:  if (bus.stop)              w_state_next = KS_IDLE;
            default:                            w_state_next = KS_IDLE;
        endcase
    end

    // Key store; the keyinput register below reads the pre-write value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_KEYS; i++) r_keys[i] <= '0;
        end else if (w_xfer && w_in_range) begin
            r_keys[bus.load_index[IDXW-1:0]] <= bus.load_data;
        end
    end

    // Registered key for the phase the core will be in next cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_keyinput <= '0;
        end else if (w_state_next == KS_RUN) begin
            r_keyinput <= r_keys[w_phase_next];
        end else begin
            r_keyinput <= '0;
        end
    end

    // Sticky load error, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_load_err <= 1'b0;
        end else if ((w_xfer && !w_in_range) || w_lock_err) begin
            r_load_err <= 1'b1;
        end
    end

    assign bus.load_ready = w_ready;
    assign bus.keyinput   = r_keyinput;
    assign bus.key_index  = w_phase;
    assign bus.key_valid  = w_run;
    assign bus.load_err   = r_load_err;

endmodule

// File: doc/cute_lock_key_sequencer.md
# cute_lock_key_sequencer

Key-side partner of the Cute-Lock multi-key structurally locked benchmarks. It stores `NUM_KEYS` keys of `KEY_BITS` each and drives the locked core's `keyinput` bus with one key per cycle. The key shown in each cycle is the one matching the core's free-running key-phase counter, which is the 2-bit `Q` counter for 4 keys. It sits between the tamper-proof key store / loader and the locked netlist, and is the block that makes an encrypted benchmark functionally unlocked at run time.

## Interface
Parameters:
- `NUM_KEYS`, 4, number of keys; power of two, 2..16.
- `KEY_BITS`, 4, width of each key and of `keyinput`.

Ports:
- `clock` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `load_valid` input 1: key write request.
- `load_ready` output 1: key write can be accepted this cycle.
- `load_index` input `$clog2(NUM_KEYS)+1`: target key slot; the extra MSB exists so out-of-range writes can be detected.
- `load_data` input `KEY_BITS`: key value.
- `sync` input 1: one-cycle pulse aligning the sequence to phase 0 of the locked core's counter.
- `stop` input 1: one-cycle pulse returning to IDLE.
- `keyinput` output `KEY_BITS`: key presented to the locked core, registered.
- `key_index` output `$clog2(NUM_KEYS)`: phase of the key currently on `keyinput`.
- `key_valid` output 1: high while in RUN.
- `load_err` output 1: sticky error flag.

## Operation
- Storage is `NUM_KEYS` × `KEY_BITS` registers.
- A write transfers when `load_valid && load_ready`.
  - `load_index < NUM_KEYS`: the slot is written at the edge.
  - `load_index >= NUM_KEYS`: the write is discarded and `load_err` is set.
- State machine has two states, IDLE and RUN.
  - IDLE → RUN on `sync`.
  - In RUN, `sync` resets the phase to 0.
  - RUN → IDLE on `stop`.
  - `stop` and `sync` in the same cycle: `stop` wins.
- In RUN the phase increments every cycle with no stalls, wrapping from `NUM_KEYS-1` to 0.
- Each cycle in RUN: `keyinput` = key[phase], `key_index` = phase, `key_valid` = 1.
- In IDLE, `keyinput`, `key_index` and `key_valid` are all 0.
- `load_ready` is 1 in IDLE. In RUN it depends on the Configuration section.
- `load_err` is cleared only by `reset`.
- Reset values: state IDLE, phase 0, all key slots 0, `keyinput` 0, `key_index` 0, `key_valid` 0, `load_err` 0, `load_ready` 1.
- Reset mid-RUN: all outputs return to these values immediately (asynchronous), and the keys are lost.

## Timing
- `sync` sampled high at edge c: `keyinput` = key[0] during cycle c+1, key[1] during c+2, and so on.
- `stop` sampled high at edge c: outputs are zero from cycle c+1.
- Write to slot i at edge c:
  - The `keyinput` register loaded at that same edge uses the pre-write content.
  - The new value appears at the next occurrence of phase i after edge c.
- `load_err` rises in the cycle after the offending transfer.

## Configuration
- `KEYSEQ_LOCKOUT_EN` defined:
  - `load_ready` = 0 in RUN; keys are immutable while streaming.
  - `load_valid` sampled high in RUN sets `load_err`.
- `KEYSEQ_LOCKOUT_EN` undefined:
  - `load_ready` = 1 in RUN.
  - In-flight writes follow the write-timing rule in Timing.
  - `load_err` is set only by out-of-range writes.

## Structure
- Shared package `cute_lock_pkg` holds:
  - State enum `keyseq_state_t` (`KS_IDLE`, `KS_RUN`).
  - Default constants `CL_NUM_KEYS`, `CL_KEY_BITS`.
  - Function `cl_idx_w(n)` returning `$clog2(n)`.
- One sub-module, `keyseq_phase_counter`:
  - Modulo-`NUM_KEYS` up-counter with synchronous clear (`sync`) and enable (RUN).
  - The same structure is reused by the lock-insertion flow.

## Test plan
- Reset, then idle for 5 cycles → `keyinput`=0, `key_valid`=0, `load_ready`=1, `load_err`=0.
- Load slots 0..3 = 0x8, 0x1, 0xD, 0x6; pulse `sync` at edge 10 → cycles 11..16 show `keyinput` 8,1,D,6,8,1 and `key_index` 0,1,2,3,0,1.
- In RUN at phase 2, pulse `sync` → next cycle `key_index`=0, `keyinput`=0x8; `sync`+`stop` together → next cycle IDLE with outputs 0.
- Out-of-range write: `load_index`=5 with `NUM_KEYS`=4 → `load_err`=1 next cycle; all slots unchanged.
- Write in RUN:
  - Without `KEYSEQ_LOCKOUT_EN`: write slot 1 = 0xF at the edge showing phase 1 → that cycle still shows 0x1; phase 1 four cycles later shows 0xF.
  - With `KEYSEQ_LOCKOUT_EN`: `load_ready`=0, `load_err`=1, slot unchanged.
- Assert `reset` asynchronously mid-cycle during RUN → `keyinput`/`key_valid` go to 0 before the next edge; after release, a `sync` streams zeros.
